mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single memory port of the multicycle MIPS core between the instruction-fetch requester and the load/store requester.
- Registers the request, drives the memory's address/enable/write strobe, and waits a parameterised read latency, so both asynchronous and registered memories fit behind it.
- Captures read data and returns a one-cycle acknowledge to the requester.
- Alternates grant on contention so neither port starves during back-to-back loads.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 32, width of byte addresses.
- MEM_LATENCY, 0, cycles from issue to valid mem_rdata; legal range 0-15; 0 means combinational read.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_ack  out  1  one-cycle pulse: fetch complete.
- if_err  out  1  valid with if_ack: misaligned address, no access made.
- if_rdata  out  DATA_WIDTH  fetched word, held until next if_ack.
- dm_req  in  1  data request, level, held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_WIDTH  data byte address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_err  out  1  valid with dm_ack: misaligned address.
- dm_rdata  out  DATA_WIDTH  load word, held until next read dm_ack.
- mem_en  out  1  access strobe to memory.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  registered address to memory.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high, overrides all state, including mid-transaction):
  - state = IDLE; all acks, errs, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0; latency counter = 0.
  - last_grant = IF, so the first contention goes to DM.
  - An aborted access produces no ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples if_req and dm_req.
  - Only one requesting: grant it.
  - Both requesting: grant the port not equal to last_grant.
  - On grant: latch addr, we (forced 0 for IF) and wdata; set last_grant; select granted port.
  - Latched addr[1:0] != 0: go to RESP with err flagged; no ISSUE, no memory access, rdata unchanged.
  - Otherwise go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we = latched we.
  - mem_addr and mem_wdata driven from latched registers; they hold through WAIT and RESP.
  - Write: go to RESP.
  - Read with MEM_LATENCY = 0: capture mem_rdata into the granted port's rdata register, go to RESP.
  - Read with MEM_LATENCY > 0: load counter = MEM_LATENCY - 1, go to WAIT.
- WAIT:
  - mem_en = 0.
  - Counter > 0: decrement.
  - Counter = 0: capture mem_rdata (exactly MEM_LATENCY cycles after ISSUE), go to RESP.
- RESP (one cycle):
  - Granted port's ack = 1; err = 1 only if misaligned.
  - Go to IDLE.
  - The other port's outputs are unaffected.
- Latency:
  - Aligned read: ack asserted 2 + MEM_LATENCY cycles after the IDLE cycle that sampled req.
  - Write: ack 2 cycles after sampling.
  - Misaligned: ack 1 cycle after sampling.
- Handshake:
  - Requester drops req in the cycle after ack.
  - req high in the IDLE cycle following RESP is a new request.
  - Request inputs are ignored outside IDLE; a request arriving mid-transaction waits.
  - Requester must hold addr/wdata/we stable while req is high; the arbiter uses only values latched in IDLE.
- Fairness: under continuous requests from both ports, grants strictly alternate.
- busy = (state != IDLE).
- mem_we is never 1 for an IF grant.

Test Plan:
- MEM_LATENCY=0; if_req with if_addr=0x04; memory returns 0x2008000A -> mem_en pulse in cycle 1, if_ack in cycle 2, if_rdata=0x2008000A, if_err=0.
- MEM_LATENCY=2; dm read at 0x10; mem_rdata valid 2 cycles after ISSUE = 0xDEADBEEF -> dm_ack at cycle 4, dm_rdata=0xDEADBEEF, if_rdata unchanged.
- if_req and dm_req both held continuously from reset for 4 transactions -> grant order DM, IF, DM, IF; each ack a single-cycle pulse.
- dm write with dm_addr=0x20, dm_wdata=0x12345678 -> exactly one cycle of mem_we=1 with mem_addr=0x20 and mem_wdata=0x12345678; dm_ack 2 cycles after sampling.
- if_addr=0x06 -> if_ack and if_err=1 one cycle after sampling; mem_en never asserted; if_rdata unchanged.
- reset asserted during WAIT (MEM_LATENCY=3) -> next cycle state IDLE, busy=0, no ack pulse; a subsequent dm_req is serviced normally with DM priority on contention.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the multicycle core between instruction fetch and load/store.
// Latency: ack 2+MEM_LATENCY cycles after grant for reads, 2 for writes, 1 for a misaligned address.
// Backpressure: requests are level-held until ack; a losing or late request waits in IDLE, and grants alternate on contention.
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic                  if_err,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic                  dm_err,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Counter reload value; WAIT is only entered when MEM_LATENCY > 0.
    localparam logic [3:0] LAT_M1  = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;
    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_DM = 1'b1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_port;
    logic                  r_last_grant;
    logic                  r_we;
    logic                  r_err;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    logic                  w_any_req;
    logic                  w_grant_dm;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_misaligned;
    logic                  w_capture;

    // Grant selection: a lone requester wins; on contention the port not granted last time wins.
    always_comb begin
        w_any_req    = if_req | dm_req;
        w_grant_dm   = dm_req & (~if_req | (r_last_grant == PORT_IF));
        w_gnt_addr   = w_grant_dm ? dm_addr : if_addr;
        w_misaligned = (w_gnt_addr[1:0] != 2'b00);
        w_capture    = ((r_state == S_ISSUE) && !r_we && (MEM_LATENCY == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe/ack decode.
    always_comb begin
        w_next = r_state;
        mem_en = 1'b0;
        mem_we = 1'b0;
        if_ack = 1'b0;
        if_err = 1'b0;
        dm_ack = 1'b0;
        dm_err = 1'b0;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en = 1'b1;
                mem_we = r_we;
                w_next = (r_we || (MEM_LATENCY == 0)) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if_ack = (r_port == PORT_IF);
                if_err = (r_port == PORT_IF) & r_err;
                dm_ack = (r_port == PORT_DM);
                dm_err = (r_port == PORT_DM) & r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch at grant, latency counter, and read-data capture into the granted port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port       <= PORT_IF;
            r_last_grant <= PORT_IF;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_port       <= w_grant_dm;
                r_last_grant <= w_grant_dm;
                r_addr       <= w_gnt_addr;
                r_we         <= w_grant_dm & dm_we;
                r_wdata      <= w_grant_dm ? dm_wdata : '0;
                r_err        <= w_misaligned;
            end
            if ((r_state == S_ISSUE) && !r_we) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                if (r_port == PORT_DM) begin
                    r_dm_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule
